// File: rtl/fifo_stream_reader.sv
// Drain stage for a FIFO with one-cycle read latency: issues credit-limited reads and presents
// the words on a valid/ready stream through a head+skid buffer, with packet framing and a count.
module fifo_stream_reader #(
    parameter int unsigned PKT_LEN = 8,
    parameter int unsigned DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_err_read,
    output logic              fifo_read,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [15:0]       word_count,
    output logic              err
);

    localparam int unsigned    IdxW    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(PKT_LEN - 1);

    logic [1:0]        occ_q, occ_d;
    logic              inflight_q;
    logic [IdxW-1:0]   pkt_idx_q, pkt_idx_d;
    logic [15:0]       word_count_q, word_count_d;
    logic              err_q, err_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] skid_q, skid_d;

    logic       pop;
    logic       push;
    logic [2:0] level;

    assign out_valid  = (occ_q != 2'd0);
    assign out_data   = head_q;
    assign out_last   = (pkt_idx_q == LastIdx);
    assign word_count = word_count_q;
    assign err        = err_q;

    // Credit check counts the word in flight and credits a same-cycle pop, so a read may be
    // issued whenever at least one slot will be free when its data lands.
    always_comb begin
        pop       = out_valid & out_ready;
        push      = inflight_q;
        level     = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_read = enable & ~fifo_empty & (level < 3'd2);
    end

    always_comb begin
        head_d = head_q;
        skid_d = skid_q;
        occ_d  = occ_q;
        unique case ({push, pop})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    head_d = fifo_data;
                end else begin
                    skid_d = fifo_data;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                if (occ_q == 2'd2) begin
                    head_d = skid_q;
                end
                occ_d = occ_q - 2'd1;
            end
            2'b11: begin
                // Occupancy is unchanged; incoming word lands behind whatever remains.
                if (occ_q == 2'd2) begin
                    head_d = skid_q;
                    skid_d = fifo_data;
                end else begin
                    head_d = fifo_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        pkt_idx_d    = pkt_idx_q;
        word_count_d = word_count_q;
        if (pop) begin
            pkt_idx_d    = (pkt_idx_q == LastIdx) ? '0 : pkt_idx_q + 1'b1;
            word_count_d = word_count_q + 16'd1;
        end
        err_d = err_q | fifo_err_read;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occ_q        <= 2'd0;
            inflight_q   <= 1'b0;
            pkt_idx_q    <= '0;
            word_count_q <= 16'd0;
            err_q        <= 1'b0;
            head_q       <= '0;
            skid_q       <= '0;
        end else begin
            occ_q        <= occ_d;
            inflight_q   <= fifo_read;
            pkt_idx_q    <= pkt_idx_d;
            word_count_q <= word_count_d;
            err_q        <= err_d;
            head_q       <= head_d;
            skid_q       <= skid_d;
        end
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Downstream drain stage for `top_fifo`. It pulls 32-bit words out of the FIFO through its `read`/`data_read`/`empty` port and accounts for the FIFO's one-cycle read latency. Words are presented on a valid/ready output stream through a 2-entry buffer, with packet framing (`out_last`) and a running word counter. The block never issues a read to an empty FIFO, and it never loses a word under output backpressure.

## Interface
- `PKT_LEN`, default 8: words per packet; `out_last` marks word `PKT_LEN-1` of each packet; legal range 1..256.
- `DATA_W`, default 32: data width; must match the FIFO width.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high; sampled on the `clk` rising edge.
- `enable` in 1: permits new FIFO reads; does not gate draining of words already fetched.
- `fifo_empty` in 1: FIFO `empty` flag.
- `fifo_data` in DATA_W: FIFO `data_read`; valid the cycle after `fifo_read`.
- `fifo_err_read` in 1: FIFO `err_read` flag.
- `fifo_read` out 1: FIFO `read` strobe.
- `out_data` out DATA_W: head word of the output buffer.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer accepts the word this cycle.
- `out_last` out 1: the head word is the last word of its packet; meaningful only while `out_valid` is high.
- `word_count` out 16: total words accepted on the output; wraps 65535 -> 0.
- `err` out 1: sticky; set when `fifo_err_read` is seen high; cleared only by reset.

## Operation
- State:
  - `occ` (0..2): output-buffer occupancy.
  - `inflight` (1 bit): a read was issued last cycle, so its data arrives this cycle.
  - `pkt_idx` (0..PKT_LEN-1).
  - `word_count`.
  - `err`.
  - Two buffer entries, organised as head plus skid.
- Read issue, combinational: `fifo_read = enable & ~fifo_empty & ((occ + inflight - pop) < 2)`, where `pop = out_valid & out_ready`.
  - The path from `out_ready` to `fifo_read` is combinational by design; it is what gives full throughput.
- Capture: when `inflight` is 1, `fifo_data` is written into the buffer this cycle.
  - It goes to the head if the buffer is empty, or becomes empty through a simultaneous pop.
  - Otherwise it goes to the skid entry.
- Pop: on `pop`, the skid entry moves to the head if it is occupied.
  - Push and pop in the same cycle leave `occ` unchanged.
- The credit rule guarantees `occ + inflight <= 2`, so no overflow is possible. The bench asserts this invariant.
- `out_valid = (occ != 0)`. `out_data` is the head entry, held stable while `out_valid & ~out_ready`.
- Framing:
  - `out_last = (pkt_idx == PKT_LEN-1)`.
  - On `pop`, `pkt_idx` increments, wrapping to 0 after PKT_LEN-1.
  - With PKT_LEN = 1, `out_last` is always 1.
- `word_count` increments by 1 on every `pop`.
- Deasserting `enable` stops new reads only. The in-flight word is still captured and buffered words still drain.
- `err` is set on any cycle with `fifo_err_read = 1`. By construction the block never causes this itself; the flag is for integration checks.
- Reset:
  - `occ = 0`, `inflight = 0`, `pkt_idx = 0`, `word_count = 0`, `err = 0`.
  - Outputs after reset: `fifo_read = 0`, `out_valid = 0`, `out_last = 0` (PKT_LEN>1), `out_data = 0`.
  - A reset coincident with, or following, an issued read discards that word. The FIFO shares the same reset.

## Timing
- Latency, FIFO to output:
  - `fifo_read` is high in cycle N and the word is captured at the end of N+1.
  - `out_valid` rises in N+2, giving 2 cycles from read strobe to presentation.
- Throughput: 1 word/cycle sustained while `out_ready = 1` and the FIFO is non-empty.
- Backpressure:
  - With `out_ready` held 0, at most 2 reads are issued after the buffer starts to fill.
  - `fifo_read` then stays 0 until a pop.
- First read after reset can be issued in the cycle after `reset` deasserts, if `enable = 1` and `~fifo_empty`.
- `fifo_empty` is sampled in the same cycle as `fifo_read`. The block never asserts `fifo_read` while `fifo_empty = 1`.

## Test plan
- Stream 20 words (0x00000001..0x00000014) with `out_ready = 1` and `enable = 1`, PKT_LEN = 8:
  - outputs appear in order, one per cycle after the 2-cycle fill;
  - `out_last` is high on words 8 and 16;
  - `word_count = 20` at the end;
  - `err = 0`.
- FIFO preloaded with 10 words, `out_ready = 0` for 10 cycles:
  - exactly 2 `fifo_read` pulses occur;
  - `out_data` is held at word 1 throughout.
- Then `out_ready = 1`: all 10 words arrive in order with no duplicates.
- Toggle `out_ready` 1,0,1,0 with random FIFO data (`$random(2)`):
  - the output sequence equals the FIFO write sequence;
  - `occ + inflight <= 2` every cycle.
- Drain to empty:
  - `fifo_read` is never high while `fifo_empty = 1`;
  - `out_valid` drops one cycle after the last pop.
- Drop `enable` mid-stream with 1 word in flight and 1 buffered:
  - both are delivered;
  - no further reads occur.
- Pulse `reset` while a read is in flight:
  - the next cycle shows `out_valid = 0`, `word_count = 0`, `pkt_idx = 0`, `err = 0`.
- Force `fifo_err_read = 1` for 1 cycle: `err` rises the next cycle and stays high until reset.
